// File: rtl/geofence_feeder.sv
// Record FIFO plus burst sequencer for the geofence core. Owns the core's reset
// line so every 6-record burst lines up with the core's fixed sampling window.
module geofence_feeder #(
  parameter int DEPTH    = 12,
  parameter int WAIT_MAX = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_x,
  input  logic [9:0]  in_y,
  input  logic [10:0] in_r,
  output logic [9:0]  X,
  output logic [9:0]  Y,
  output logic [10:0] R,
  output logic        core_reset,
  input  logic        core_valid,
  output logic [15:0] groups_sent,
  output logic        err_timeout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [CW-1:0] GROUP   = CW'(6);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WAIT_MAX - 1);

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]    state, next_state;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    burst;
  logic [WW-1:0] wd;
  logic          ready_block;
  logic          push, pop;
  logic [30:0]   mem [DEPTH];

  // ready_block keeps the host out for the first cycle after reset
  assign in_ready = !ready_block && (count < FULL);
  assign push     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_x, in_y, in_r};
  end

  // Record 0 is popped on the edge that enters SEND so it is on X/Y/R in the
  // first SEND cycle; the remaining five pop during SEND bursts 0..4.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      S_HOLD: begin
        if (count >= GROUP) begin
          next_state = S_SEND;
          pop        = 1'b1;
        end
      end
      S_SEND: begin
        if (burst == 3'd5) next_state = S_WAIT;
        else               pop        = 1'b1;
      end
      S_WAIT: begin
        if (core_valid) begin
          if (count >= GROUP) begin
            next_state = S_SEND;
            pop        = 1'b1;
          end else begin
            next_state = S_HOLD;
          end
        end else if (wd == WD_LAST) begin
          next_state = S_HOLD;
        end
      end
      default: next_state = S_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_HOLD;
      core_reset  <= 1'b1;
      ready_block <= 1'b1;
      X           <= '0;
      Y           <= '0;
      R           <= '0;
      groups_sent <= '0;
      err_timeout <= 1'b0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      burst       <= '0;
      wd          <= '0;
    end else begin
      state       <= next_state;
      core_reset  <= (next_state == S_HOLD);
      ready_block <= 1'b0;

      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr      <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
        {X, Y, R}   <= mem[rd_ptr];
      end

      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      burst <= (state == S_SEND && next_state == S_SEND) ? burst + 3'd1 : 3'd0;
      wd    <= (state == S_WAIT && next_state == S_WAIT) ? wd + WW'(1) : '0;

      if (state == S_SEND && next_state == S_WAIT) groups_sent <= groups_sent + 16'd1;
      if (state == S_WAIT && !core_valid && wd == WD_LAST) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_geofence_feeder.sv
// Bench for geofence_feeder: directed table, multi-cycle corner sequences and a
// randomized run, all checked against a queue-based model of the feeder.
module tb_geofence_feeder;

  localparam int DEPTH    = 12;
  localparam int WAIT_MAX = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_x, in_y;
  logic [10:0] in_r;
  logic [9:0]  X, Y;
  logic [10:0] R;
  logic        core_reset;
  logic        core_valid;
  logic [15:0] groups_sent;
  logic        err_timeout;

  geofence_feeder #(.DEPTH(DEPTH), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_r(in_r), .X(X), .Y(Y), .R(R),
    .core_reset(core_reset), .core_valid(core_valid),
    .groups_sent(groups_sent), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;
  logic track_cr = 1'b0;
  logic cr_seen  = 1'b0;

  // Model: a record queue plus "where are we in the core's schedule".
  typedef enum int {M_HOLD, M_SEND, M_WAIT} mode_t;
  logic [30:0] q[$];
  mode_t       m_mode    = M_HOLD;
  int          m_left    = 0;
  int          m_elapsed = 0;
  logic [30:0] m_out     = '0;
  logic        m_cr      = 1'b1;
  logic        m_blk     = 1'b1;
  logic [15:0] m_groups  = '0;
  logic        m_err     = 1'b0;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [30:0] d;
    logic        cr;
    logic        rdy;
    logic [9:0]  ex;
    logic [15:0] g;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [30:0] rec(int i);
    return {10'(i * 7 + 1), 10'(i * 13 + 2), 11'(i * 29 + 3)};
  endfunction

  function automatic vec_t mk_vec(logic rst, logic iv, int x, int y, int r,
                                  logic cr, logic rdy, int ex, int g);
    vec_t v;
    v.rst = rst; v.iv = iv; v.d = {10'(x), 10'(y), 11'(r)};
    v.cr = cr; v.rdy = rdy; v.ex = 10'(ex); v.g = 16'(g);
    return v;
  endfunction

  task automatic check_value(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic start_burst();
    m_out  = q.pop_front();
    m_left = 5;
    m_mode = M_SEND;
    m_cr   = 1'b0;
  endtask

  task automatic model_edge();
    logic acc;
    int   avail;
    if (reset) begin
      q.delete();
      m_mode = M_HOLD; m_left = 0; m_elapsed = 0; m_out = '0;
      m_cr = 1'b1; m_blk = 1'b1; m_groups = '0; m_err = 1'b0;
    end else begin
      acc   = in_valid && !m_blk && (q.size() < DEPTH);
      avail = q.size();
      case (m_mode)
        M_HOLD: if (avail >= 6) start_burst();
        M_SEND: begin
          if (m_left > 0) begin
            m_out = q.pop_front();
            m_left--;
          end else begin
            m_mode = M_WAIT; m_elapsed = 0; m_groups++;
          end
        end
        default: begin
          if (core_valid) begin
            if (avail >= 6) start_burst();
            else begin m_mode = M_HOLD; m_cr = 1'b1; end
          end else begin
            m_elapsed++;
            if (m_elapsed == WAIT_MAX) begin
              m_mode = M_HOLD; m_cr = 1'b1; m_err = 1'b1;
            end
          end
        end
      endcase
      if (acc) q.push_back({in_x, in_y, in_r});
      m_blk = 1'b0;
    end
  endtask

  task automatic checkOutput();
    check_value("X", 32'(X), 32'(m_out[30:21]));
    check_value("Y", 32'(Y), 32'(m_out[20:11]));
    check_value("R", 32'(R), 32'(m_out[10:0]));
    check_value("core_reset", 32'(core_reset), 32'(m_cr));
    check_value("in_ready", 32'(in_ready), 32'(!m_blk && (q.size() < DEPTH)));
    check_value("groups_sent", 32'(groups_sent), 32'(m_groups));
    check_value("err_timeout", 32'(err_timeout), 32'(m_err));
  endtask

  // Drive one cycle of inputs, clock it, advance the model, then compare.
  task automatic applyStimulus(logic r, logic iv, logic [30:0] d, logic cv);
    reset = r; in_valid = iv; {in_x, in_y, in_r} = d; core_valid = cv;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    checkOutput();
    if (track_cr) cr_seen = cr_seen | core_reset;
  endtask

  task automatic idle_until(int target);
    for (int i = cyc; i < target; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic push_rec(int i);
    applyStimulus(1'b0, 1'b1, rec(i), 1'b0);
  endtask

  int base;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_r = '0; core_valid = 1'b0;

    tbl[0] = mk_vec(1, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[1] = mk_vec(0, 0, 0, 0, 0, 1, 1, 0, 0);
    for (int k = 1; k <= 6; k++)
      tbl[k + 1] = mk_vec(0, 1, 100 * k, 100 * k + 100, 100 * k + 200, 1, 1, 0, 0);
    tbl[8] = mk_vec(0, 0, 0, 0, 0, 0, 1, 100, 0);
    for (int k = 1; k <= 5; k++)
      tbl[8 + k] = mk_vec(0, 0, 0, 0, 0, 0, 1, 100 * (k + 1), 0);
    tbl[14] = mk_vec(0, 0, 0, 0, 0, 0, 1, 600, 1);

    // Row n holds cycle-n inputs and the outputs expected in cycle n+1.
    for (int n = 0; n < 15; n++) begin
      applyStimulus(tbl[n].rst, tbl[n].iv, tbl[n].d, 1'b0);
      check_value("tbl_core_reset", 32'(core_reset), 32'(tbl[n].cr));
      check_value("tbl_in_ready", 32'(in_ready), 32'(tbl[n].rdy));
      check_value("tbl_X", 32'(X), 32'(tbl[n].ex));
      check_value("tbl_groups", 32'(groups_sent), 32'(tbl[n].g));
    end

    // Watchdog: WAIT entered in cycle 15, HOLD 64 cycles later.
    idle_until(78);
    check_value("wd_pre_cr", 32'(core_reset), 32'd0);
    check_value("wd_pre_err", 32'(err_timeout), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    check_value("wd_cr", 32'(core_reset), 32'd1);
    check_value("wd_err", 32'(err_timeout), 32'd1);

    // Preload 12, valid 20 cycles after burst 1, back-to-back bursts.
    base = cyc;
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    idle_until(base + 2);
    for (int i = 0; i < 12; i++) push_rec(i);
    idle_until(base + 9);
    track_cr = 1'b1;
    idle_until(base + 34);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    check_value("b2_first_x", 32'(X), 32'(rec(6) >> 21));
    idle_until(base + 41);
    track_cr = 1'b0;
    check_value("b2_groups", 32'(groups_sent), 32'd2);
    check_value("b2_cr_never_high", 32'(cr_seen), 32'd0);

    // Valid with an empty FIFO drops to HOLD; refill restarts 2 cycles later.
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    check_value("hold_cr", 32'(core_reset), 32'd1);
    for (int i = 12; i < 18; i++) push_rec(i);
    check_value("refill_cr_hi", 32'(core_reset), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    check_value("refill_cr_lo", 32'(core_reset), 32'd0);
    check_value("refill_x", 32'(X), 32'(rec(12) >> 21));

    // Fill to DEPTH during WAIT; extra valids must be refused.
    idle_until(base + 55);
    for (int i = 18; i < 30; i++) push_rec(i);
    check_value("full_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, rec(900 + i), 1'b0);
    check_value("full_ready_held", 32'(in_ready), 32'd0);
    idle_until(base + 118);
    check_value("wd2_err_pre", 32'(err_timeout), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    check_value("wd2_cr", 32'(core_reset), 32'd1);
    check_value("wd2_err", 32'(err_timeout), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    check_value("full_burst_x", 32'(X), 32'(rec(18) >> 21));
    for (int i = 30; i < 36; i++) push_rec(i);

    // Reset during record 3 of burst 2.
    base = cyc;
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    idle_until(base + 2);
    for (int i = 40; i < 52; i++) push_rec(i);
    idle_until(base + 16);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    idle_until(base + 20);
    check_value("rst_pre_x", 32'(X), 32'(rec(49) >> 21));
    check_value("rst_pre_groups", 32'(groups_sent), 32'd1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    check_value("rst_cr", 32'(core_reset), 32'd1);
    check_value("rst_ready", 32'(in_ready), 32'd0);
    check_value("rst_groups", 32'(groups_sent), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    check_value("rst_ready_after", 32'(in_ready), 32'd1);
    idle_until(base + 30);
    check_value("rst_discarded", 32'(core_reset), 32'd1);

    // Randomized traffic; rare core_valid late on to exercise timeouts.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 499) == 0,
                    $urandom_range(0, 9) < 6,
                    31'($urandom),
                    (n < 1500) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
